// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file write-port controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rf_ctrl_pkg;

   localparam int         NREGS  = 15;
   localparam logic [3:0] PC_REG = 4'hF;
   localparam int         RF_AW  = 4;
   localparam int         RF_DW  = 32;

   typedef enum logic {
      INIT,
      ARB
   } state_e;

   typedef enum logic {
      REQ_A,
      REQ_B
   } req_e;

   // One register-file write: enable, r15-drop flag, address, data.
   typedef struct packed {
      logic             we;
      logic             err;
      logic [RF_AW-1:0] addr;
      logic [RF_DW-1:0] data;
   } wr_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the requester that did not win last time wins a tie.
// Latency: purely combinational.
// Backpressure: a requester with valid low is never granted.
module rr_arb2
   import rf_ctrl_pkg::*;
(
   input  logic       valid_a_i,
   input  logic       valid_b_i,
   input  req_e       last_grant_i,
   output logic [1:0] grant_o       // bit 0 = A, bit 1 = B, one-hot or zero
);

   // Lone requester always wins; on a tie, alternate away from last_grant.
   always_comb begin
      grant_o = 2'b00;
      if (valid_a_i && valid_b_i) begin
         grant_o = (last_grant_i == REQ_A) ? 2'b10 : 2'b01;
      end else if (valid_a_i) begin
         grant_o = 2'b01;
      end else if (valid_b_i) begin
         grant_o = 2'b10;
      end
   end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Initialises r0..r(NREGS-1) after reset, then arbitrates two writeback requesters onto one RF write port.
// Latency: one cycle from accepted request (or init step) to we3/wa3/wd3.
// Backpressure: readies are low during init; in ARB only the granted requester sees ready, the other holds its request.
module rf_wport_arbiter
   import rf_ctrl_pkg::*;
#(
   parameter logic [RF_DW-1:0] INIT_VALUE = 32'h0000_0000,
   parameter int               NREGS      = rf_ctrl_pkg::NREGS
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [RF_AW-1:0] a_addr,
   input  logic [RF_DW-1:0] a_data,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic [RF_AW-1:0] b_addr,
   input  logic [RF_DW-1:0] b_data,
   output logic             we3,
   output logic [RF_AW-1:0] wa3,
   output logic [RF_DW-1:0] wd3,
   output logic             init_done,
   output logic             r15_err
);

   // Counter value one past the last init write; in this slot the r14 write
   // is retiring from the output stage, so no new write is issued and the
   // state moves to ARB at the end of it.
   localparam logic [RF_AW-1:0] DRAIN_CNT = RF_AW'(NREGS);

   state_e           state_q, state_d;
   logic [RF_AW-1:0] cnt_q, cnt_d;
   req_e             last_grant_q, last_grant_d;
   wr_t              wr_q, wr_d;

   logic [1:0]       grant;
   logic             xfer_a;
   logic             xfer_b;

   rr_arb2 u_rr_arb2 (
      .valid_a_i    (a_valid),
      .valid_b_i    (b_valid),
      .last_grant_i (last_grant_q),
      .grant_o      (grant)
   );

   assign xfer_a = a_valid && a_ready;
   assign xfer_b = b_valid && b_ready;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: leave INIT once the last init write has retired.
   always_comb begin
      state_d = state_q;
      if (state_q == INIT && cnt_q == DRAIN_CNT) begin
         state_d = ARB;
      end
   end

   // FSM outputs: readies only in ARB and only to the granted requester.
   always_comb begin
      a_ready   = 1'b0;
      b_ready   = 1'b0;
      init_done = 1'b0;
      if (state_q == ARB) begin
         a_ready   = grant[0];
         b_ready   = grant[1];
         init_done = 1'b1;
      end
   end

   // Init counter advances once per INIT cycle and parks in ARB.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == INIT) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Remember who won the last transfer, including dropped r15 writes.
   always_comb begin
      last_grant_d = last_grant_q;
      if (xfer_a) begin
         last_grant_d = REQ_A;
      end else if (xfer_b) begin
         last_grant_d = REQ_B;
      end
   end

   // Next write-port contents: an init step, an accepted request, or idle.
   // Address/data hold when idle; only the enable and error flag drop.
   always_comb begin
      wr_d     = wr_q;
      wr_d.we  = 1'b0;
      wr_d.err = 1'b0;
      if (state_q == INIT) begin
         if (cnt_q != DRAIN_CNT) begin
            wr_d.we   = 1'b1;
            wr_d.addr = cnt_q;
            wr_d.data = INIT_VALUE;
         end
      end else if (xfer_a || xfer_b) begin
         wr_d.addr = xfer_a ? a_addr : b_addr;
         wr_d.data = xfer_a ? a_data : b_data;
         if (wr_d.addr == PC_REG) begin
            wr_d.err = 1'b1;
         end else begin
            wr_d.we  = 1'b1;
         end
      end
   end

   // Counter, last grant and the single registered write-port stage.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q        <= '0;
         last_grant_q <= REQ_B;
         wr_q         <= '0;
      end else begin
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         wr_q         <= wr_d;
      end
   end

   assign we3     = wr_q.we;
   assign wa3     = wr_q.addr;
   assign wd3     = wr_q.data;
   assign r15_err = wr_q.err;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
module tb_rf_wport_arbiter;

   logic        clk;
   logic        reset_n;
   logic        a_valid, a_ready;
   logic [3:0]  a_addr;
   logic [31:0] a_data;
   logic        b_valid, b_ready;
   logic [3:0]  b_addr;
   logic [31:0] b_data;
   logic        we3;
   logic [3:0]  wa3;
   logic [31:0] wd3;
   logic        init_done;
   logic        r15_err;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   rf_wport_arbiter dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_addr    (a_addr),
      .a_data    (a_data),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .b_addr    (b_addr),
      .b_data    (b_data),
      .we3       (we3),
      .wa3       (wa3),
      .wd3       (wd3),
      .init_done (init_done),
      .r15_err   (r15_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Releases reset (must be low on entry) and checks the init sweep.
   // stop_at > 0 returns right after checking that cycle.
   task automatic run_init(input string tag, input int stop_at);
      a_valid = 1'b1; a_addr = 4'h9; a_data = 32'h9999_9999;
      b_valid = 1'b1; b_addr = 4'hA; b_data = 32'hAAAA_AAAA;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk_cnt++;
      if ({we3, a_ready, b_ready, init_done} !== 4'b0000)
         $display("FAIL %s_cycle0: we3/a_rdy/b_rdy/done got %b want 0000", tag, {we3, a_ready, b_ready, init_done});
      else pass_cnt++;
      for (int k = 1; k <= 15; k++) begin
         tick;
         chk_cnt++;
         if ({we3, wa3, wd3} !== {1'b1, 4'(k - 1), 32'h0000_0000})
            $display("FAIL %s_write%0d: we3/wa3/wd3 got %b/%h/%h want 1/%h/00000000", tag, k, we3, wa3, wd3, 4'(k - 1));
         else pass_cnt++;
         chk_cnt++;
         if ({a_ready, b_ready, init_done, r15_err} !== 4'b0000)
            $display("FAIL %s_ctl%0d: a_rdy/b_rdy/done/err got %b want 0000", tag, k, {a_ready, b_ready, init_done, r15_err});
         else pass_cnt++;
         if (k == stop_at) return;
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      tick;
      chk_cnt++;
      if ({init_done, we3} !== 2'b10)
         $display("FAIL %s_done: init_done/we3 got %b want 10", tag, {init_done, we3});
      else pass_cnt++;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      a_valid = 1'b1; a_addr = 4'h3; a_data = 32'h1111_1111;
      b_valid = 1'b1; b_addr = 4'h4; b_data = 32'h2222_2222;
      tick;
      tick;
      chk_cnt++;
      if ({we3, wa3, wd3, r15_err, init_done, a_ready, b_ready} !== 41'h0)
         $display("FAIL reset_outputs: got %h want 0", {we3, wa3, wd3, r15_err, init_done, a_ready, b_ready});
      else pass_cnt++;
   endtask

   task automatic test_init;
      run_init("init", 0);
   endtask

   // Both requesters held valid: A wins first (last_grant resets to B), then alternate.
   task automatic test_tie;
      a_valid = 1'b1; a_addr = 4'h1; a_data = 32'hAAAA_0001;
      b_valid = 1'b1; b_addr = 4'h2; b_data = 32'hBBBB_0002;
      #1;
      chk_cnt++;
      if ({a_ready, b_ready} !== 2'b10)
         $display("FAIL tie_first_ready: a/b got %b want 10", {a_ready, b_ready});
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk_cnt++;
         if ((i % 2) == 0) begin
            if ({we3, wa3, wd3} !== {1'b1, 4'h1, 32'hAAAA_0001})
               $display("FAIL tie_write%0d: got %b/%h/%h want 1/1/aaaa0001", i, we3, wa3, wd3);
            else pass_cnt++;
         end else begin
            if ({we3, wa3, wd3} !== {1'b1, 4'h2, 32'hBBBB_0002})
               $display("FAIL tie_write%0d: got %b/%h/%h want 1/2/bbbb0002", i, we3, wa3, wd3);
            else pass_cnt++;
         end
         chk_cnt++;
         if ({a_ready, b_ready} !== (((i % 2) == 0) ? 2'b01 : 2'b10))
            $display("FAIL tie_ready%0d: a/b got %b want %b", i, {a_ready, b_ready}, (((i % 2) == 0) ? 2'b01 : 2'b10));
         else pass_cnt++;
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      tick;
      chk_cnt++;
      if (we3 !== 1'b0)
         $display("FAIL tie_idle: we3 got %b want 0", we3);
      else pass_cnt++;
   endtask

   task automatic test_single;
      b_valid = 1'b1; b_addr = 4'h5; b_data = 32'h1234_5678;
      #1;
      chk_cnt++;
      if ({a_ready, b_ready} !== 2'b01)
         $display("FAIL single_ready: a/b got %b want 01", {a_ready, b_ready});
      else pass_cnt++;
      tick;
      b_valid = 1'b0;
      chk_cnt++;
      if ({we3, wa3, wd3} !== {1'b1, 4'h5, 32'h1234_5678})
         $display("FAIL single_write: got %b/%h/%h want 1/5/12345678", we3, wa3, wd3);
      else pass_cnt++;
      tick;
      chk_cnt++;
      if (we3 !== 1'b0)
         $display("FAIL single_idle: we3 got %b want 0", we3);
      else pass_cnt++;
   endtask

   // Losing requester holds; its data changes while waiting and the new value is written.
   task automatic test_back_to_back;
      a_valid = 1'b1; a_addr = 4'h7; a_data = 32'h7777_0000;
      b_valid = 1'b1; b_addr = 4'h6; b_data = 32'h6666_0000;
      #1;
      chk_cnt++;
      if ({a_ready, b_ready} !== 2'b10)
         $display("FAIL b2b_ready_a: a/b got %b want 10", {a_ready, b_ready});
      else pass_cnt++;
      tick;
      a_valid = 1'b0;
      b_data  = 32'h6666_1111;
      chk_cnt++;
      if ({we3, wa3, wd3} !== {1'b1, 4'h7, 32'h7777_0000})
         $display("FAIL b2b_write_a: got %b/%h/%h want 1/7/77770000", we3, wa3, wd3);
      else pass_cnt++;
      #1;
      chk_cnt++;
      if ({a_ready, b_ready} !== 2'b01)
         $display("FAIL b2b_ready_b: a/b got %b want 01", {a_ready, b_ready});
      else pass_cnt++;
      tick;
      b_valid = 1'b0;
      chk_cnt++;
      if ({we3, wa3, wd3} !== {1'b1, 4'h6, 32'h6666_1111})
         $display("FAIL b2b_write_b: got %b/%h/%h want 1/6/66661111", we3, wa3, wd3);
      else pass_cnt++;
      tick;
      chk_cnt++;
      if (we3 !== 1'b0)
         $display("FAIL b2b_idle: we3 got %b want 0", we3);
      else pass_cnt++;
   endtask

   // r15 write is accepted, dropped, flagged for one cycle, and still moves last_grant to A.
   task automatic test_pc_write;
      a_valid = 1'b1; a_addr = 4'hF; a_data = 32'hDEAD_BEEF;
      #1;
      chk_cnt++;
      if (a_ready !== 1'b1)
         $display("FAIL pc_ready: a_ready got %b want 1", a_ready);
      else pass_cnt++;
      tick;
      a_valid = 1'b0;
      chk_cnt++;
      if ({we3, r15_err} !== 2'b01)
         $display("FAIL pc_err: we3/r15_err got %b want 01", {we3, r15_err});
      else pass_cnt++;
      tick;
      chk_cnt++;
      if ({we3, r15_err} !== 2'b00)
         $display("FAIL pc_err_pulse: we3/r15_err got %b want 00", {we3, r15_err});
      else pass_cnt++;
      a_valid = 1'b1; a_addr = 4'h1; a_data = 32'hAAAA_0001;
      b_valid = 1'b1; b_addr = 4'h2; b_data = 32'hBBBB_0002;
      #1;
      chk_cnt++;
      if ({a_ready, b_ready} !== 2'b01)
         $display("FAIL pc_last_grant: a/b got %b want 01", {a_ready, b_ready});
      else pass_cnt++;
      tick;
      a_valid = 1'b0;
      b_valid = 1'b0;
      chk_cnt++;
      if ({we3, wa3, wd3} !== {1'b1, 4'h2, 32'hBBBB_0002})
         $display("FAIL pc_next_write: got %b/%h/%h want 1/2/bbbb0002", we3, wa3, wd3);
      else pass_cnt++;
      tick;
   endtask

   task automatic test_reset_mid;
      reset_n = 1'b0;
      tick;
      run_init("mid_init", 7);
      reset_n = 1'b0;
      #1;
      chk_cnt++;
      if ({we3, wa3, init_done} !== 6'b0)
         $display("FAIL mid_init_abort: we3/wa3/done got %b want 0", {we3, wa3, init_done});
      else pass_cnt++;
      tick;
      run_init("restart1", 0);
      a_valid = 1'b1; a_addr = 4'h3; a_data = 32'h3333_3333;
      tick;
      chk_cnt++;
      if ({we3, wa3, wd3} !== {1'b1, 4'h3, 32'h3333_3333})
         $display("FAIL mid_arb_write: got %b/%h/%h want 1/3/33333333", we3, wa3, wd3);
      else pass_cnt++;
      reset_n = 1'b0;
      #1;
      chk_cnt++;
      if ({we3, a_ready, init_done} !== 3'b000)
         $display("FAIL mid_arb_abort: we3/a_rdy/done got %b want 000", {we3, a_ready, init_done});
      else pass_cnt++;
      a_valid = 1'b0;
      tick;
      run_init("restart2", 0);
   endtask

   initial begin
      reset_n = 1'b0;
      a_valid = 1'b0; a_addr = '0; a_data = '0;
      b_valid = 1'b0; b_addr = '0; b_data = '0;
      test_reset;
      test_init;
      test_tie;
      test_single;
      test_back_to_back;
      test_pc_write;
      test_reset_mid;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/rf_wport_arbiter.md
RF_WPORT_ARBITER -- requirements
Module: rf_wport_arbiter

Interface
REQ-001 The module SHALL have parameter INIT_VALUE, default 32'h0000_0000, the value written to r0-r14 during post-reset initialisation.
REQ-002 The module SHALL have parameter NREGS, default 15, the number of writable registers; r15 is the PC and is not writable.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit: reset that is asynchronous and active-low.
REQ-005 The module SHALL have ports a_valid (input, 1), a_ready (output, 1), a_addr (input, 4) and a_data (input, 32): the write request from the ALU/execute writeback.
REQ-006 The module SHALL have ports b_valid (input, 1), b_ready (output, 1), b_addr (input, 4) and b_data (input, 32): the write request from the load/memory writeback.
REQ-007 The module SHALL have ports we3 (output, 1), wa3 (output, 4) and wd3 (output, 32), driving the register-file write port directly.
REQ-008 The module SHALL have port init_done, output, 1 bit, high once r0-r14 are initialised.
REQ-009 The module SHALL have port r15_err, output, 1 bit: a one-cycle pulse when a request addressed to r15 is accepted and dropped.

Function
REQ-010 The block SHALL have two states: INIT and ARB.
REQ-011 In INIT, a 4-bit counter SHALL step 0..NREGS-1, with one write per cycle: we3=1, wa3=counter, wd3=INIT_VALUE.
- INIT takes exactly 15 cycles.
- After the write to r14, the state SHALL become ARB.
REQ-012 In INIT, a_ready and b_ready SHALL be 0. init_done SHALL be 0 in INIT and 1 in ARB.
REQ-013 A transfer SHALL occur on a requester when valid && ready at a rising edge; at most one transfer SHALL occur per cycle.
REQ-014 In ARB, ready SHALL be combinational from the valids and the last_grant flop.
- Only A valid: a_ready=1.
- Only B valid: b_ready=1.
- Both valid: the ready goes to the requester not in last_grant.
- Neither valid: both readies are 0.
REQ-015 last_grant SHALL update to the accepted requester on each transfer and hold otherwise, so a continuously valid requester is granted within 2 cycles.
REQ-016 An accepted request SHALL appear on we3/wa3/wd3 in the following cycle (1-cycle registered latency).
- we3 SHALL be 0 in every ARB cycle that follows a cycle with no transfer.
REQ-017 An accepted request with addr==4'hF SHALL produce we3=0 and r15_err=1 for exactly the following cycle.
- The transfer still counts for last_grant.
REQ-018 Valid requests held across cycles SHALL NOT be dropped; the data/addr presented at the transfer edge is what is written.
REQ-019 Back-to-back writes from alternating requesters SHALL sustain one write per cycle with no bubble.

Reset
REQ-020 While reset_n=0, the outputs SHALL be: we3=0, wa3=0, wd3=0, r15_err=0, init_done=0, a_ready=0, b_ready=0.
- Internal state SHALL be: state=INIT, counter=0, last_grant=B (so A wins the first tie).
REQ-021 Assertion of reset_n mid-INIT or mid-ARB SHALL abandon any in-flight write (we3 low immediately) and restart INIT from r0 after release.
REQ-022 The first INIT write (r0) SHALL appear in the first cycle after reset_n deasserts.

Structure
REQ-023 A shared package rf_ctrl_pkg SHALL hold the following.
- The state enum {INIT, ARB}.
- The requester enum {REQ_A, REQ_B}.
- The constants NREGS=15, PC_REG=4'hF, RF_AW=4, RF_DW=32.
REQ-024 Round-robin grant logic SHALL live in one sub-module rr_arb2.
- Inputs: two valids, last_grant.
- Outputs: one-hot grant.
REQ-025 The write-port output SHALL be a single registered stage; the block SHALL contain no storage beyond the counter, state, last_grant and that stage.

Verification
REQ-026 Reset release: reset_n 0->1, then observe 15 cycles -> we3=1 with wa3=0..14 and wd3=0 in consecutive cycles; init_done=1 from cycle 16; readies 0 throughout INIT.
REQ-027 Tie: a_valid=b_valid=1 held after init, with a_addr=1, a_data=32'hAAAA_0001, b_addr=2, b_data=32'hBBBB_0002.
- Expected: writes alternate in the order A(r1), B(r2), A, B, one per cycle.
REQ-028 Single requester: only b_valid=1 with b_addr=5, b_data=32'h1234_5678.
- Expected: b_ready=1 in the same cycle; next cycle we3=1, wa3=5, wd3=32'h1234_5678; the cycle after that, we3=0.
REQ-029 PC write: a_valid=1, a_addr=4'hF, a_data=32'hDEAD_BEEF.
- Expected: a_ready=1; next cycle we3=0 and r15_err=1 for one cycle only.
REQ-030 Reset mid-operation: reset_n=0 during INIT at counter=7, and again during an ARB write.
- Expected: we3=0 immediately; after release, INIT restarts at wa3=0 and runs the full 15 cycles.
